ring_osc_freq_meter: RTL and testbench
======================================

# ring_osc_freq_meter

Single-clock measurement controller for the ring-oscillator array. It enables one ring at a time, waits a settle interval, then counts that ring's rising edges over a power-of-two gate window of `clk` cycles and holds the result for readout. It sits between the ring/divider outputs and the user I/O and sequences which oscillator runs. Only the selected ring is powered, so the rings do not couple.

## Interface
- `N_OSC`, 4: number of oscillator inputs; `SEL_W = max(1, $clog2(N_OSC))`.
- `CNT_W`, 16: edge-counter and result width.
- `SETTLE_CYCLES`, 16: cycles between ring enable and gate open; must be ≥ 3.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `osc_in`  in  N_OSC  raw ring or divider outputs, asynchronous to `clk`; each must be below `clk`/2.
- `osc_en`  out  N_OSC  per-ring enable; one-hot or zero.
- `start`  in  1  measurement request; sampled only in IDLE.
- `abort`  in  1  cancel the running measurement.
- `sel`  in  SEL_W  oscillator index; latched on accepted `start`.
- `gate_log2`  in  4  gate length G = 2^gate_log2 cycles; latched on accepted `start`.
- `busy`  out  1  high from SETTLE through MEASURE.
- `done`  out  1  one-cycle pulse when a new result is valid.
- `count`  out  CNT_W  last result; held until the next `done`.
- `overflow`  out  1  the last result saturated.
- `err`  out  1  the last request had `sel ≥ N_OSC`.

## Operation
- Registered FSM with states IDLE, SETTLE, MEASURE.
- IDLE: `osc_en`=0 and `busy`=0.
  - On `start`=1 with a valid `sel`: latch `sel` and `gate_log2` and go to SETTLE.
  - On `start`=1 with `sel ≥ N_OSC`: stay in IDLE, pulse `done` next cycle with `count`=0, `overflow`=0, `err`=1.
- SETTLE: `osc_en[sel_q]`=1 and `busy`=1. Run a settle counter for SETTLE_CYCLES cycles, then go to MEASURE.
- MEASURE:
  - `osc_en[sel_q]` stays 1; a gate counter runs for G cycles.
  - The selected input is muxed by `sel_q`, passed through a 2-FF synchronizer and an edge-detect FF.
  - Each cycle that detects a 0→1 edge increments the edge counter. The counter saturates at all-ones and sets a sticky overflow bit.
  - After G cycles: load `count`, `overflow` and `err`=0, pulse `done`, and return to IDLE.
- The edge counter and overflow bit clear on entry to MEASURE. Edges seen during SETTLE are never counted.
- The synchronizer and edge FF run continuously. SETTLE ≥ 3 guarantees they are flushed with the new `sel_q` before the gate opens.
- `abort`=1 in SETTLE or MEASURE: next cycle go to IDLE with `osc_en`=0, `busy`=0, no `done`, and `count`/`overflow`/`err` unchanged. `abort` in IDLE is ignored.
- `start` while busy is ignored. `abort` has priority over gate completion in the same cycle.
- Reset (`rst_n`=0 at a `clk` edge), in any state including mid-MEASURE, gives:
  - state IDLE;
  - all outputs 0: `osc_en`, `busy`, `done`, `count`, `overflow`, `err`;
  - synchronizer, edge FF, edge counter, settle counter and gate counter all cleared.

## Timing
- `start` accepted at edge T. The following outputs are all registered:
  - T+1: `busy`=1 and `osc_en[sel]`=1.
  - MEASURE covers cycles T+S+1 … T+S+G, where S = SETTLE_CYCLES.
  - T+S+G+1: `done`=1, `count` valid, `busy`=0, `osc_en`=0.
- Total latency is S+G+1 cycles. A new `start` is accepted in the `done` cycle.
- The edge count lags the raw input by 3 cycles (2 sync + 1 edge FF). Window alignment is therefore offset by 3 cycles, with ±1 edge quantisation.
- An invalid-`sel` request has `done` at T+1 and `busy` never asserts.
- `gate_log2`=0 gives a 1-cycle gate. `gate_log2`=15 gives a 32768-cycle gate.

## Structure
- Package `ringosc_pkg` holds:
  - the state enum (IDLE/SETTLE/MEASURE);
  - the gate-select width constant (4);
  - the minimum settle constant (3).
- Sub-module `osc_edge_sync` contains the 2-FF synchronizer and the rising-edge detector, with synchronous active-low reset. The top instantiates one copy after the `sel_q` mux.
- The top holds the FSM, the settle/gate counters, the saturating edge counter and the result registers.

## Test plan
- `osc_in[2]` square wave, period 8 clk, `sel`=2, `gate_log2`=6. Required response:
  - `osc_en`=4'b0100 during busy;
  - `done` at T+S+65;
  - `count`=8 ±1, `overflow`=0.
- `osc_in[1]` held 0, `gate_log2`=4 → `count`=0, `done` at T+S+17.
- Parameter override CNT_W=4, period-4 input, `gate_log2`=6 (16 edges) → `count`=15, `overflow`=1.
- `abort` mid-MEASURE after a prior result of 8:
  - IDLE next cycle, `osc_en`=0;
  - no `done`; `count` stays 8.
- `start` pulsed while busy → ignored; exactly one `done`. `start` in the `done` cycle → accepted, `busy`=1 next cycle.
- `rst_n` low mid-SETTLE → next cycle all outputs 0 and state IDLE. A fresh measurement then returns the correct count.

Source files
------------

// File: rtl/ringosc_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package ringosc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2
    } meter_state_e;

    localparam int GATE_SEL_W = 4;
    localparam int MIN_SETTLE = 3;
    localparam int GATE_CNT_W = (1 << GATE_SEL_W) - 1;

    // Gate down-counter reload: 2^g - 1, so the terminal count lands on the G-th cycle.
    function automatic logic [GATE_CNT_W-1:0] gate_len_m1(input logic [GATE_SEL_W-1:0] g);
        logic [GATE_CNT_W:0] len;
        len = (GATE_CNT_W + 1)'(1) << g;
        return GATE_CNT_W'(len - (GATE_CNT_W + 1)'(1));
    endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchronizer for an asynchronous ring output followed by a
// rising-edge detector; runs continuously so a new selection flushes through.
module osc_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic osc,
    output logic rise
);
    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], osc};
            prev_q <= sync_q[1];
        end
    end

    assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator frequency meter: powers one ring, lets it settle, then counts
// its rising edges over a 2^gate_log2 cycle gate and holds the result.
module ring_osc_freq_meter
    import ringosc_pkg::*;
#(
    parameter int  N_OSC         = 4,
    parameter int  CNT_W         = 16,
    parameter int  SETTLE_CYCLES = 16,
    localparam int SEL_W         = (N_OSC > 1) ? $clog2(N_OSC) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_OSC-1:0]      osc_in,
    output logic [N_OSC-1:0]      osc_en,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SEL_W-1:0]      sel,
    input  logic [GATE_SEL_W-1:0] gate_log2,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  err
);
    // Settle shorter than the sync+edge pipeline depth would leak the previous ring's edges.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < MIN_SETTLE) ? MIN_SETTLE : SETTLE_CYCLES;
    localparam int ST_W       = $clog2(SETTLE_EFF + 1);
    localparam logic [ST_W-1:0]  SETTLE_LOAD = ST_W'(SETTLE_EFF - 1);
    localparam logic [SEL_W:0]   N_OSC_W     = (SEL_W + 1)'(N_OSC);

    meter_state_e            state, state_n;
    logic [SEL_W-1:0]        sel_q, sel_n;
    logic [GATE_SEL_W-1:0]   gate_q;
    logic [ST_W-1:0]         settle_cnt;
    logic [GATE_CNT_W-1:0]   gate_cnt;
    logic [CNT_W-1:0]        edge_cnt, edge_sum;
    logic                    edge_ovf, ovf_sum;
    logic [N_OSC-1:0]        sel_onehot;
    logic                    sel_ok, accept, reject, enter_measure, finish;
    logic                    osc_mux, rise;

    assign sel_ok = ({1'b0, sel} < N_OSC_W);
    assign sel_n  = accept ? sel : sel_q;

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < N_OSC; i++) begin
            sel_onehot[i] = (sel_n == SEL_W'(i));
        end
    end

    always_comb begin
        osc_mux = 1'b0;
        for (int i = 0; i < N_OSC; i++) begin
            osc_mux |= osc_in[i] & (sel_q == SEL_W'(i));
        end
    end

    osc_edge_sync u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .osc   (osc_mux),
        .rise  (rise)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        accept        = 1'b0;
        reject        = 1'b0;
        enter_measure = 1'b0;
        finish        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (sel_ok) begin
                        accept  = 1'b1;
                        state_n = ST_SETTLE;
                    end else begin
                        reject  = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (settle_cnt == '0) begin
                    enter_measure = 1'b1;
                    state_n       = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // Abort wins over gate completion in the same cycle.
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (gate_cnt == '0) begin
                    finish  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // The edge seen in the last gate cycle must reach the result, hence the combinational sum.
    always_comb begin
        edge_sum = edge_cnt;
        ovf_sum  = edge_ovf;
        if (rise) begin
            if (edge_cnt == '1) begin
                ovf_sum = 1'b1;
            end else begin
                edge_sum = edge_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q      <= '0;
            gate_q     <= '0;
            settle_cnt <= '0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            edge_ovf   <= 1'b0;
            osc_en     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            overflow   <= 1'b0;
            err        <= 1'b0;
        end else begin
            osc_en <= (state_n != ST_IDLE) ? sel_onehot : '0;
            busy   <= (state_n != ST_IDLE);
            done   <= finish | reject;

            if (accept) begin
                sel_q      <= sel;
                gate_q     <= gate_log2;
                settle_cnt <= SETTLE_LOAD;
            end else if (state == ST_SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - ST_W'(1);
            end

            if (enter_measure) begin
                gate_cnt <= gate_len_m1(gate_q);
                edge_cnt <= '0;
                edge_ovf <= 1'b0;
            end else if (state == ST_MEASURE) begin
                if (gate_cnt != '0) begin
                    gate_cnt <= gate_cnt - GATE_CNT_W'(1);
                end
                edge_cnt <= edge_sum;
                edge_ovf <= ovf_sum;
            end

            if (finish) begin
                count    <= edge_sum;
                overflow <= ovf_sum;
                err      <= 1'b0;
            end else if (reject) begin
                count    <= '0;
                overflow <= 1'b0;
                err      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Bench for ring_osc_freq_meter: directed vector table, hand-written corner
// sequences and randomized runs against a sample-history edge-count model.
module tb_ring_osc_freq_meter;
    localparam int S = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;

    logic [3:0]  osc_a = '0;
    logic [3:0]  en_a;
    logic        start_a = 1'b0, abort_a = 1'b0;
    logic [1:0]  sel_a = '0;
    logic [3:0]  g_a = '0;
    logic        busy_a, done_a, ovf_a, err_a;
    logic [15:0] cnt_a;

    logic [2:0]  en_b;
    logic        start_b = 1'b0, abort_b = 1'b0;
    logic [1:0]  sel_b = '0;
    logic [3:0]  g_b = '0;
    logic        busy_b, done_b, ovf_b, err_b;
    logic [3:0]  cnt_b;

    ring_osc_freq_meter #(.N_OSC(4), .CNT_W(16), .SETTLE_CYCLES(S)) dut_a (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_a), .osc_en(en_a), .start(start_a),
        .abort(abort_a), .sel(sel_a), .gate_log2(g_a), .busy(busy_a), .done(done_a),
        .count(cnt_a), .overflow(ovf_a), .err(err_a));

    ring_osc_freq_meter #(.N_OSC(3), .CNT_W(4), .SETTLE_CYCLES(S)) dut_b (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_a[2:0]), .osc_en(en_b), .start(start_b),
        .abort(abort_b), .sel(sel_b), .gate_log2(g_b), .busy(busy_b), .done(done_b),
        .count(cnt_b), .overflow(ovf_b), .err(err_b));

    // Square-wave sources: period 0 holds the channel at lvl.
    int   per [4] = '{0, 0, 0, 0};
    int   off [4] = '{0, 0, 0, 0};
    logic lvl [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int   gcnt = 0;

    always @(negedge clk) begin
        gcnt = gcnt + 1;
        for (int i = 0; i < 4; i++) begin
            if (per[i] == 0) osc_a[i] = lvl[i];
            else             osc_a[i] = (((gcnt + off[i]) % per[i]) < (per[i] / 2));
        end
    end

    // Raw input as seen at each rising clk edge, indexed by edge number.
    logic [3:0] hist [0:65535];
    int         cyc = 0;
    always @(posedge clk) begin
        hist[cyc[15:0]] <= osc_a;
        cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_near(input string name, input int act, input int exp, input int tol);
        n_cmp++;
        if (act < exp - tol || act > exp + tol) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d+-%0d", name, act, exp, tol);
        end
    endtask

    // Rising transitions of the raw samples in the gate window moved 3 cycles earlier
    // (sync + edge pipeline); the meter may differ by one edge at the window ends.
    function automatic int model_cnt(input int s, input int t, input int g);
        int n = 0;
        for (int j = t + S - 2; j <= t + S + g - 3; j++) begin
            if (hist[j-1][s] === 1'b0 && hist[j][s] === 1'b1) n++;
        end
        return n;
    endfunction

    // One measurement on dut_a; exp_cnt < 0 means use the reference model with +-1.
    task automatic meas_a(input string tag, input int s, input int g, input int exp_cnt);
        int t, lat, glen, exp_v, tol;
        glen = 1 << g;
        @(negedge clk);
        sel_a = 2'(s); g_a = 4'(g); start_a = 1'b1; t = cyc;
        @(negedge clk);
        start_a = 1'b0;
        chk({tag, ".busy"}, int'(busy_a), 1);
        chk({tag, ".osc_en"}, int'(en_a), 1 << s);
        lat = 1;
        while (!done_a && lat < 40000) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, lat, S + glen + 1);
        if (exp_cnt < 0) begin
            exp_v = model_cnt(s, t, glen);
            tol   = 1;
        end else begin
            exp_v = exp_cnt;
            tol   = 0;
        end
        chk_near({tag, ".count"}, int'(cnt_a), exp_v, tol);
        chk({tag, ".overflow"}, int'(ovf_a), 0);
        chk({tag, ".err"}, int'(err_a), 0);
        chk({tag, ".busy_end"}, int'(busy_a), 0);
        chk({tag, ".en_end"}, int'(en_a), 0);
    endtask

    typedef struct {
        int   sel;
        int   g;
        int   period;
        logic level;
        int   exp_cnt;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int lat, ndone;

        // Gates that are whole multiples of the period give an exact count.
        tbl[0] = '{sel: 2, g: 6, period: 8, level: 1'b0, exp_cnt: 8};
        tbl[1] = '{sel: 1, g: 4, period: 0, level: 1'b0, exp_cnt: 0};
        tbl[2] = '{sel: 3, g: 3, period: 4, level: 1'b0, exp_cnt: 2};
        tbl[3] = '{sel: 0, g: 5, period: 8, level: 1'b0, exp_cnt: 4};
        tbl[4] = '{sel: 1, g: 0, period: 0, level: 1'b1, exp_cnt: 0};

        repeat (3) @(negedge clk);
        chk("rst.osc_en", int'(en_a), 0);
        chk("rst.busy", int'(busy_a), 0);
        chk("rst.done", int'(done_a), 0);
        chk("rst.count", int'(cnt_a), 0);
        chk("rst.overflow", int'(ovf_a), 0);
        chk("rst.err", int'(err_a), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) begin
                per[i] = 3; off[i] = i;
            end
            per[tbl[v].sel] = tbl[v].period;
            lvl[tbl[v].sel] = tbl[v].level;
            repeat (4) @(negedge clk);
            meas_a($sformatf("vec%0d", v), tbl[v].sel, tbl[v].g, tbl[v].exp_cnt);
            lvl[tbl[v].sel] = 1'b0;
        end

        // Invalid selection on the 3-ring instance.
        @(negedge clk);
        sel_b = 2'd3; g_b = 4'd2; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("inv.done", int'(done_b), 1);
        chk("inv.err", int'(err_b), 1);
        chk("inv.count", int'(cnt_b), 0);
        chk("inv.busy", int'(busy_b), 0);
        chk("inv.osc_en", int'(en_b), 0);
        @(negedge clk);
        chk("inv.done_pulse", int'(done_b), 0);

        // 4-bit counter saturation: 16 edges in a 64-cycle gate.
        per[0] = 4;
        @(negedge clk);
        sel_b = 2'd0; g_b = 4'd6; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        lat = 1;
        while (!done_b && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        chk("sat.latency", lat, S + 65);
        chk("sat.count", int'(cnt_b), 15);
        chk("sat.overflow", int'(ovf_b), 1);
        chk("sat.err", int'(err_b), 0);

        // Abort mid-MEASURE keeps the previous result.
        for (int i = 0; i < 4; i++) per[i] = 3;
        per[2] = 8;
        meas_a("pre_abort", 2, 6, 8);
        @(negedge clk);
        sel_a = 2'd2; g_a = 4'd6; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (S + 10) @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort.busy", int'(busy_a), 0);
        chk("abort.osc_en", int'(en_a), 0);
        ndone = 0;
        for (int k = 0; k < 100; k++) begin
            if (done_a) ndone++;
            @(negedge clk);
        end
        chk("abort.no_done", ndone, 0);
        chk("abort.count", int'(cnt_a), 8);

        // start while busy is ignored; start in the done cycle is accepted.
        per[1] = 0; lvl[1] = 1'b0;
        @(negedge clk);
        sel_a = 2'd2; g_a = 4'd4; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        lat = 1; ndone = 0;
        while (lat < S + 17) begin
            if (lat == 5 || lat == S + 3) begin
                sel_a = 2'd1; g_a = 4'd0; start_a = 1'b1;
            end else begin
                start_a = 1'b0;
            end
            if (done_a) ndone++;
            @(negedge clk);
            lat++;
        end
        start_a = 1'b0;
        if (done_a) ndone++;
        chk("busy_start.ndone", ndone, 1);
        chk("busy_start.done_cycle", int'(done_a), 1);
        chk("busy_start.count", int'(cnt_a), 2);
        sel_a = 2'd1; g_a = 4'd0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("done_start.busy", int'(busy_a), 1);
        chk("done_start.osc_en", int'(en_a), 2);
        lat = 1;
        while (!done_a && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        chk("done_start.latency", lat, S + 2);
        chk("done_start.count", int'(cnt_a), 0);

        // Reset mid-SETTLE, then a fresh measurement.
        meas_a("pre_rst", 2, 6, 8);
        @(negedge clk);
        sel_a = 2'd2; g_a = 4'd6; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst.osc_en", int'(en_a), 0);
        chk("mid_rst.busy", int'(busy_a), 0);
        chk("mid_rst.done", int'(done_a), 0);
        chk("mid_rst.count", int'(cnt_a), 0);
        chk("mid_rst.overflow", int'(ovf_a), 0);
        chk("mid_rst.err", int'(err_a), 0);
        meas_a("post_rst", 2, 6, 8);

        // Randomized runs against the sample-history model.
        for (int r = 0; r < 12; r++) begin
            int s, g;
            for (int i = 0; i < 4; i++) begin
                per[i] = int'($urandom_range(3, 24));
                off[i] = int'($urandom_range(0, 23));
            end
            s = int'($urandom_range(0, 3));
            g = int'($urandom_range(0, 8));
            repeat (3) @(negedge clk);
            meas_a($sformatf("rnd%0d", r), s, g, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
